// File: rtl/fib_bcd_conv.sv
// Iterative double-dabble converter: 64-bit binary in over Avalon-ST,
// packed BCD plus significant-digit count out over Avalon-ST with backpressure.
module fib_bcd_conv #(
    parameter int DATA_W = 64,
    parameter int DIGITS = 20,
    parameter int CNT_W  = 5
) (
    input  logic                  CLK,
    input  logic                  RESET,
    output logic                  ASI_READY,
    input  logic                  ASI_VALID,
    input  logic [DATA_W-1:0]     ASI_DATA,
    input  logic                  ASI_ERROR,
    input  logic                  ASO_READY,
    output logic                  ASO_VALID,
    output logic [4*DIGITS-1:0]   ASO_DATA,
    output logic [CNT_W-1:0]      ASO_DIGITS,
    output logic                  ASO_ERROR,
    output logic                  OVERRUN
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int BIT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE,
        S_OUT
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                asi_ready_q, asi_ready_d;
    logic                aso_valid_q, aso_valid_d;
    logic [BCD_W-1:0]    aso_data_q, aso_data_d;
    logic [CNT_W-1:0]    aso_digits_q, aso_digits_d;
    logic                aso_error_q, aso_error_d;
    logic                overrun_q, overrun_d;

    logic [BCD_W-1:0]    bcd_adj;
    logic [CNT_W-1:0]    top_digits;

    // Add-3 correction: a digit >= 5 becomes at most 12, so it stays in its nibble.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Highest nonzero digit index + 1; an all-zero value still reports one digit.
    always_comb begin
        top_digits = CNT_W'(1);
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                top_digits = CNT_W'(i + 1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bcd_d        = bcd_q;
        bit_cnt_d    = bit_cnt_q;
        aso_valid_d  = aso_valid_q;
        aso_data_d   = aso_data_q;
        aso_digits_d = aso_digits_q;
        aso_error_d  = aso_error_q;
        overrun_d    = overrun_q | (ASI_VALID & ~asi_ready_q);

        case (state_q)
            S_IDLE: begin
                if (ASI_VALID && asi_ready_q) begin
                    shift_d   = ASI_DATA;
                    bcd_d     = '0;
                    bit_cnt_d = BIT_W'(DATA_W);
                    if (ASI_ERROR) begin
                        aso_data_d   = '0;
                        aso_digits_d = '0;
                        aso_error_d  = 1'b1;
                        state_d      = S_OUT;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                bcd_d     = {bcd_adj[BCD_W-2:0], shift_q[DATA_W-1]};
                shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q - BIT_W'(1);
                if (bit_cnt_q == BIT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                aso_data_d   = bcd_q;
                aso_digits_d = top_digits;
                aso_error_d  = 1'b0;
                state_d      = S_OUT;
            end
            S_OUT: begin
                // Valid rises one edge after entering OUT; data is already stable.
                if (!aso_valid_q) begin
                    aso_valid_d = 1'b1;
                end else if (ASO_READY) begin
                    aso_valid_d = 1'b0;
                    aso_error_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        asi_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            bcd_q        <= '0;
            bit_cnt_q    <= '0;
            asi_ready_q  <= 1'b1;
            aso_valid_q  <= 1'b0;
            aso_data_q   <= '0;
            aso_digits_q <= '0;
            aso_error_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bcd_q        <= bcd_d;
            bit_cnt_q    <= bit_cnt_d;
            asi_ready_q  <= asi_ready_d;
            aso_valid_q  <= aso_valid_d;
            aso_data_q   <= aso_data_d;
            aso_digits_q <= aso_digits_d;
            aso_error_q  <= aso_error_d;
            overrun_q    <= overrun_d;
        end
    end

    assign ASI_READY  = asi_ready_q;
    assign ASO_VALID  = aso_valid_q;
    assign ASO_DATA   = aso_data_q;
    assign ASO_DIGITS = aso_digits_q;
    assign ASO_ERROR  = aso_error_q;
    assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_fib_bcd_conv.sv
// Directed bench for fib_bcd_conv: hand-computed vectors plus a divide-by-10
// golden model for F1..F93.
module tb_fib_bcd_conv;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ASI_READY;
    logic        ASI_VALID;
    logic [63:0] ASI_DATA;
    logic        ASI_ERROR;
    logic        ASO_READY;
    logic        ASO_VALID;
    logic [79:0] ASO_DATA;
    logic [4:0]  ASO_DIGITS;
    logic        ASO_ERROR;
    logic        OVERRUN;

    int checks = 0;
    int errors = 0;

    fib_bcd_conv #(.DATA_W(64), .DIGITS(20), .CNT_W(5)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ASI_READY  (ASI_READY),
        .ASI_VALID  (ASI_VALID),
        .ASI_DATA   (ASI_DATA),
        .ASI_ERROR  (ASI_ERROR),
        .ASO_READY  (ASO_READY),
        .ASO_VALID  (ASO_VALID),
        .ASO_DATA   (ASO_DATA),
        .ASO_DIGITS (ASO_DIGITS),
        .ASO_ERROR  (ASO_ERROR),
        .OVERRUN    (OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one beat, lets it be accepted, then scrambles ASI_DATA.
    task automatic start(input logic [63:0] data, input logic err);
        check("ready_before_accept", {79'd0, ASI_READY}, 80'd1);
        ASI_VALID = 1'b1;
        ASI_DATA  = data;
        ASI_ERROR = err;
        tick();
        ASI_VALID = 1'b0;
        ASI_ERROR = 1'b0;
        ASI_DATA  = {$urandom, $urandom};
    endtask

    // Counts edges after the accepting edge until ASO_VALID, bounded.
    task automatic wait_valid(input string tag, input int exp_lat, input int already);
        int n;
        n = already;
        while (!ASO_VALID && n < 300) begin
            tick();
            n++;
        end
        check(tag, 80'(n), 80'(exp_lat));
    endtask

    function automatic logic [79:0] to_bcd(input logic [63:0] v);
        logic [79:0] r;
        logic [63:0] t;
        r = '0;
        t = v;
        for (int i = 0; i < 20; i++) begin
            r[4*i +: 4] = 4'(t % 64'd10);
            t = t / 64'd10;
        end
        return r;
    endfunction

    function automatic logic [79:0] num_digits(input logic [63:0] v);
        logic [63:0] t;
        int n;
        t = v;
        n = 0;
        do begin
            t = t / 64'd10;
            n++;
        end while (t != 64'd0);
        return 80'(n);
    endfunction

    task automatic convert(input string tag, input logic [63:0] data,
                           input logic [79:0] exp_bcd, input logic [79:0] exp_dig);
        start(data, 1'b0);
        wait_valid({tag, "_latency"}, 66, 0);
        check({tag, "_data"}, ASO_DATA, exp_bcd);
        check({tag, "_digits"}, 80'(ASO_DIGITS), exp_dig);
        check({tag, "_error"}, {79'd0, ASO_ERROR}, 80'd0);
        tick();
        check({tag, "_valid_after_xfer"}, {79'd0, ASO_VALID}, 80'd0);
        check({tag, "_ready_after_xfer"}, {79'd0, ASI_READY}, 80'd1);
    endtask

    initial begin
        logic [79:0] held_data;
        logic [79:0] held_dig;
        logic [63:0] fa, fb, fn;
        int          stuck;

        RESET     = 1'b1;
        ASI_VALID = 1'b0;
        ASI_DATA  = '0;
        ASI_ERROR = 1'b0;
        ASO_READY = 1'b1;
        repeat (3) tick();
        RESET = 1'b0;

        check("rst_asi_ready", {79'd0, ASI_READY}, 80'd1);
        check("rst_aso_valid", {79'd0, ASO_VALID}, 80'd0);
        check("rst_aso_data", ASO_DATA, 80'd0);
        check("rst_aso_digits", 80'(ASO_DIGITS), 80'd0);
        check("rst_aso_error", {79'd0, ASO_ERROR}, 80'd0);
        check("rst_overrun", {79'd0, OVERRUN}, 80'd0);
        tick();
        check("idle_ready_held", {79'd0, ASI_READY}, 80'd1);

        // T1..T3
        convert("t1_zero", 64'd0, 80'h0, 80'd1);
        convert("t2_f50", 64'd12586269025, 80'h12586269025, 80'd11);
        convert("t3_max", 64'hFFFF_FFFF_FFFF_FFFF, 80'h18446744073709551615, 80'd20);
        convert("t3_f93", 64'd12200160415121876738, 80'h12200160415121876738, 80'd20);

        // T4: error bypass
        start(64'd101, 1'b1);
        wait_valid("t4_latency", 1, 0);
        check("t4_error", {79'd0, ASO_ERROR}, 80'd1);
        check("t4_data", ASO_DATA, 80'd0);
        check("t4_digits", 80'(ASO_DIGITS), 80'd0);
        tick();
        check("t4_error_cleared", {79'd0, ASO_ERROR}, 80'd0);
        check("t4_ready_after_xfer", {79'd0, ASI_READY}, 80'd1);

        // T5: backpressure hold
        ASO_READY = 1'b0;
        start(64'd999, 1'b0);
        wait_valid("t5_latency", 66, 0);
        held_data = ASO_DATA;
        held_dig  = 80'(ASO_DIGITS);
        check("t5_data", held_data, 80'h999);
        check("t5_digits", held_dig, 80'd3);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5_hold", {ASO_DATA[74:0], ASO_DIGITS, ASO_ERROR, ASO_VALID, ASI_READY},
                  {held_data[74:0], held_dig[4:0], 1'b0, 1'b1, 1'b0});
        end
        ASO_READY = 1'b1;
        tick();
        check("t5_valid_after_xfer", {79'd0, ASO_VALID}, 80'd0);
        check("t5_ready_after_xfer", {79'd0, ASI_READY}, 80'd1);
        check("t5_data_kept", ASO_DATA, 80'h999);
        tick();
        check("t5_single_xfer", {79'd0, ASO_VALID}, 80'd0);

        // T6: overrun during SHIFT leaves the in-flight result intact
        start(64'd42, 1'b0);
        repeat (10) tick();
        ASI_VALID = 1'b1;
        ASI_DATA  = 64'd777;
        tick();
        ASI_VALID = 1'b0;
        check("t6_overrun", {79'd0, OVERRUN}, 80'd1);
        check("t6_ready_busy", {79'd0, ASI_READY}, 80'd0);
        wait_valid("t6_latency", 66, 11);
        check("t6_data", ASO_DATA, 80'h42);
        check("t6_digits", 80'(ASO_DIGITS), 80'd2);
        tick();

        // T6: reset at SHIFT cycle 30 aborts
        start(64'd12586269025, 1'b0);
        repeat (30) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("t6_rst_overrun", {79'd0, OVERRUN}, 80'd0);
        check("t6_rst_ready", {79'd0, ASI_READY}, 80'd1);
        stuck = 0;
        for (int i = 0; i < 100; i++) begin
            if (ASO_VALID) stuck++;
            tick();
        end
        check("t6_no_output_after_abort", 80'(stuck), 80'd0);

        // F1..F93 against the golden model
        fa = 64'd0;
        fb = 64'd1;
        for (int k = 1; k <= 93; k++) begin
            convert($sformatf("fib%0d", k), fb, to_bcd(fb), num_digits(fb));
            fn = fa + fb;
            fa = fb;
            fb = fn;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
